// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage skid register: payload defaults,
// the occupancy-encoded state type and a packed payload record.
package pipe_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    localparam logic [INST_W_DEF-1:0] ZeroWord    = '0;
    localparam logic [INST_W_DEF-1:0] NopInstDef  = ZeroWord;

    // State encoding equals the number of held entries, so the state register
    // doubles as the occupancy output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
    } pipe_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid bit plus payload register. Clear wins over load; the payload is
// left untouched on clear because the output mux masks it on the valid bit.
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid/payload register with clear priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with a 2-entry skid buffer carrying {pc, inst}.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high on the same side (push = up_valid & up_ready, pop = dn_valid &
// dn_ready); dn_* stay stable while dn_valid is high and dn_ready is low,
// and up_ready is a register that depends only on the next occupancy.
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [PC_W-1:0]   up_pc,
    input  logic [INST_W-1:0] up_inst,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [PC_W-1:0]   dn_pc,
    output logic [INST_W-1:0] dn_inst,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int W = PC_W + INST_W;

    skid_state_t state;
    skid_state_t next_state;

    logic         push;
    logic         pop;
    logic         head_load;
    logic         head_clear;
    logic [W-1:0] head_d;
    logic         head_valid;
    logic [W-1:0] head_q;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [W-1:0] skid_q;
    logic [W-1:0] up_word;

    assign up_word = {up_pc, up_inst};
    assign push    = up_valid & up_ready;
    assign pop     = head_valid & dn_ready;

    // Next-state and slot control; flush overrides every transfer
    always_comb begin
        next_state = state;
        head_load  = 1'b0;
        head_clear = 1'b0;
        head_d     = up_word;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_load  = 1'b1;
                    next_state = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_load  = 1'b1;
                end else if (push) begin
                    skid_load  = 1'b1;
                    next_state = FULL;
                end else if (pop) begin
                    head_clear = 1'b1;
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // up_ready is low here, so only the pop path exists
                if (pop) begin
                    head_d     = skid_q;
                    head_load  = 1'b1;
                    skid_clear = 1'b1;
                    next_state = ONE;
                end
            end
            default: begin
                head_clear = 1'b1;
                skid_clear = 1'b1;
                next_state = EMPTY;
            end
        endcase
        if (flush) begin
            head_load  = 1'b0;
            skid_load  = 1'b0;
            head_clear = 1'b1;
            skid_clear = 1'b1;
            next_state = EMPTY;
        end
    end

    // FSM state and registered up_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            up_ready <= 1'b1;
        end else begin
            state    <= next_state;
            up_ready <= (next_state != FULL);
        end
    end

    pipe_slot #(.W(W)) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .valid (head_valid),
        .q     (head_q)
    );

    pipe_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (up_word),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign occupancy = state;
    assign dn_valid  = head_valid;
    assign dn_pc     = head_valid ? head_q[W-1:INST_W] : '0;
    assign dn_inst   = head_valid ? head_q[INST_W-1:0] : NOP_INST;

    // Saturating count of edges that see no valid output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!head_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    // Occupancy never reaches 3 and the skid slot is valid exactly when FULL
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occupancy != 2'd3);
            assert ((state == FULL) == skid_valid);
            assert ((state != EMPTY) == head_valid);
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed scenarios plus a randomized phase, with a
// capacity-2 FIFO reference model checked on every falling edge.
module tb_pipe_reg_skid;
    import pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0;
    localparam int CNT_MAX = 65535;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT signals
    logic        flush    = 1'b0;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [31:0] up_pc    = '0;
    logic [31:0] up_inst  = '0;
    logic        dn_valid;
    logic        dn_ready = 1'b0;
    logic [31:0] dn_pc;
    logic [31:0] dn_inst;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    // small-counter DUT signals
    logic        rst4   = 1'b1;
    logic        flush4 = 1'b0;
    logic        up_ready4;
    logic        dn_valid4;
    logic [31:0] dn_pc4;
    logic [31:0] dn_inst4;
    logic [1:0]  occupancy4;
    logic [3:0]  bubble_cnt4;

    pipe_reg_skid dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_pc      (up_pc),
        .up_inst    (up_inst),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_pc      (dn_pc),
        .dn_inst    (dn_inst),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    pipe_reg_skid #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .flush      (flush4),
        .up_valid   (1'b0),
        .up_ready   (up_ready4),
        .up_pc      (32'h0),
        .up_inst    (32'h0),
        .dn_valid   (dn_valid4),
        .dn_ready   (1'b1),
        .dn_pc      (dn_pc4),
        .dn_inst    (dn_inst4),
        .occupancy  (occupancy4),
        .bubble_cnt (bubble_cnt4)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    int m_cnt = 0;
    int sz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against a 2-deep FIFO model, then advances the model
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            sz = exp_q.size();
            check("occupancy", 64'(occupancy), 64'(sz));
            check("up_ready", 64'(up_ready), 64'(sz < 2));
            check("dn_valid", 64'(dn_valid), 64'(sz > 0));
            check("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
            if (sz == 0) begin
                check("bubble_pc", 64'(dn_pc), 64'h0);
                check("bubble_inst", 64'(dn_inst), 64'(NOP));
            end else begin
                check("head_payload", {dn_pc, dn_inst}, exp_q[0]);
            end
            if (sz == 0 && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (sz > 0 && dn_ready) void'(exp_q.pop_front());
                if (up_valid && sz < 2) exp_q.push_back({up_pc, up_inst});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic uv, input logic [31:0] pc, input logic dr, input logic fl);
        up_valid = uv;
        up_pc    = pc;
        up_inst  = pc ^ 32'hA5A5_0000;
        dn_ready = dr;
        flush    = fl;
        tick();
    endtask

    initial begin
        // reset both DUTs, release just after an edge
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst4 = 1'b0;

        // 1. idle after reset
        repeat (5) tick();
        check("t1_dn_valid", 64'(dn_valid), 64'h0);
        check("t1_dn_inst", 64'(dn_inst), 64'(NOP));
        check("t1_up_ready", 64'(up_ready), 64'h1);
        check("t1_bubble_cnt", 64'(bubble_cnt), 64'd5);

        // 2. streaming with dn_ready=1
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        check("t2_pc100", 64'(dn_pc), 64'h100);
        drive(1'b1, 32'h104, 1'b1, 1'b0);
        check("t2_pc104", 64'(dn_pc), 64'h104);
        check("t2_occ", 64'(occupancy), 64'd1);
        drive(1'b1, 32'h108, 1'b1, 1'b0);
        check("t2_pc108", 64'(dn_pc), 64'h108);
        check("t2_occ", 64'(occupancy), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t2_drained", 64'(dn_valid), 64'h0);

        // 3. back-pressure fills the skid slot
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        check("t3_occ", 64'(occupancy), 64'd2);
        check("t3_up_ready", 64'(up_ready), 64'h0);
        check("t3_hold_pc", 64'(dn_pc), 64'h200);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_still_pc", 64'(dn_pc), 64'h200);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t3_next_pc", 64'(dn_pc), 64'h204);
        check("t3_up_ready_back", 64'(up_ready), 64'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t3_empty", 64'(dn_valid), 64'h0);

        // 4. flush while FULL with upstream offering 0x300
        drive(1'b1, 32'h2A0, 1'b0, 1'b0);
        drive(1'b1, 32'h2A4, 1'b0, 1'b0);
        check("t4_full", 64'(occupancy), 64'd2);
        drive(1'b1, 32'h300, 1'b1, 1'b1);
        check("t4_occ", 64'(occupancy), 64'd0);
        check("t4_dn_valid", 64'(dn_valid), 64'h0);
        check("t4_up_ready", 64'(up_ready), 64'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_no_300", 64'(dn_valid), 64'h0);

        // 5. async reset between edges mid-stream
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        drive(1'b1, 32'h404, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_dn_valid", 64'(dn_valid), 64'h0);
        check("t5_up_ready", 64'(up_ready), 64'h1);
        check("t5_dn_pc", 64'(dn_pc), 64'h0);
        check("t5_dn_inst", 64'(dn_inst), 64'(NOP));
        check("t5_occ", 64'(occupancy), 64'd0);
        check("t5_bubble", 64'(bubble_cnt), 64'd0);
        up_valid = 1'b0;
        tick();
        rst = 1'b0;

        // randomized phase
        for (int i = 0; i < 2000; i++) begin
            up_valid = ($urandom_range(0, 3) != 0);
            up_pc    = $urandom;
            up_inst  = $urandom;
            dn_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 40) == 0);
            tick();
        end
        up_valid = 1'b0;
        flush    = 1'b0;
        dn_ready = 1'b1;
        repeat (3) tick();

        // 6. 4-bit counter saturation, unaffected by flush
        rst4 = 1'b1;
        #1;
        check("t6_reset", 64'(bubble_cnt4), 64'd0);
        tick();
        rst4 = 1'b0;
        repeat (14) tick();
        check("t6_count14", 64'(bubble_cnt4), 64'd14);
        repeat (6) tick();
        check("t6_saturated", 64'(bubble_cnt4), 64'd15);
        flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        repeat (2) tick();
        check("t6_after_flush", 64'(bubble_cnt4), 64'd15);
        check("t6_dn_inst", 64'(dn_inst4), 64'(NOP));

        // final report
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
